// File: rtl/led_mode_controller.sv
// Two-switch LED mode sequencer: synchronized, debounced switches; release of switch 1
// advances OFF/ALL_ON/BLINK/CHASE, release of switch 2 toggles a pause that freezes the display.
module led_mode_controller #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int BLINK_HALF     = 6250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode,
  output logic       o_Paused
);

  localparam int CW = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int TW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);
  localparam logic [TW-1:0] TMR_MAX = TW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_ALL_ON = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_CHASE  = 2'b11
  } mode_t;

  // Bit 0 carries switch 1, bit 1 carries switch 2.
  logic [1:0]    w_raw;
  logic [1:0]    r_meta, r_sync, r_level, r_level_d;
  logic [CW-1:0] r_cnt [2];
  logic [1:0]    w_ev;

  assign w_raw = {i_Switch_2, i_Switch_1};
  assign w_ev  = r_level_d & ~r_level;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_meta    <= '0;
      r_sync    <= '0;
      r_level   <= '0;
      r_level_d <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_meta    <= w_raw;
      r_sync    <= r_meta;
      r_level_d <= r_level;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_level[i] <= r_sync[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  mode_t         r_mode, w_mode_next;
  logic          r_paused, w_paused_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic          r_phase, w_phase_next;
  logic [3:0]    r_pos, w_pos_next;
  logic [3:0]    r_led, w_led_next;
  logic          w_tick;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_mode   <= MODE_OFF;
      r_paused <= 1'b0;
      r_timer  <= '0;
      r_phase  <= 1'b1;
      r_pos    <= 4'b0001;
      r_led    <= 4'b0000;
    end else begin
      r_mode   <= w_mode_next;
      r_paused <= w_paused_next;
      r_timer  <= w_timer_next;
      r_phase  <= w_phase_next;
      r_pos    <= w_pos_next;
      r_led    <= w_led_next;
    end
  end

  // A mode change wins over a same-cycle pause toggle and restarts the display from entry.
  always_comb begin
    w_mode_next   = r_mode;
    w_paused_next = r_paused;
    w_timer_next  = r_timer;
    w_phase_next  = r_phase;
    w_pos_next    = r_pos;
    w_led_next    = 4'b0000;
    w_tick        = !r_paused && (r_timer == TMR_MAX);

    if (w_ev[0]) begin
      case (r_mode)
        MODE_OFF:    w_mode_next = MODE_ALL_ON;
        MODE_ALL_ON: w_mode_next = MODE_BLINK;
        MODE_BLINK:  w_mode_next = MODE_CHASE;
        default:     w_mode_next = MODE_OFF;
      endcase
      w_paused_next = 1'b0;
      w_timer_next  = '0;
      w_phase_next  = 1'b1;
      w_pos_next    = 4'b0001;
    end else begin
      if (w_ev[1]) w_paused_next = !r_paused;
      if (!r_paused) w_timer_next = w_tick ? '0 : r_timer + 1'b1;
      if (w_tick) begin
        w_phase_next = !r_phase;
        w_pos_next   = {r_pos[2:0], r_pos[3]};
      end
    end

    case (w_mode_next)
      MODE_OFF:    w_led_next = 4'b0000;
      MODE_ALL_ON: w_led_next = 4'b1111;
      MODE_BLINK:  w_led_next = {4{w_phase_next}};
      default:     w_led_next = w_pos_next;
    endcase
  end

  assign o_LED_1  = r_led[0];
  assign o_LED_2  = r_led[1];
  assign o_LED_3  = r_led[2];
  assign o_LED_4  = r_led[3];
  assign o_Mode   = r_mode;
  assign o_Paused = r_paused;

endmodule

// File: doc/led_mode_controller.md
# led_mode_controller

- Sequences the board's four LEDs through display modes under two user switches.
- Each switch is synchronized and debounced; its release (falling edge of the debounced level) is the user event.
- Switch 1 release advances the mode; switch 2 release toggles pause.
- Sits between the raw board switch pins and the LED pins, replacing ad-hoc per-LED toggle logic.

## Interface

- DEBOUNCE_LIMIT, 250000, consecutive cycles a synchronized switch must hold a new level before the debounced level changes (10 ms at 25 MHz); ≥2.
- BLINK_HALF, 6250000, cycles per display tick (250 ms at 25 MHz); ≥2.
- i_Clk  input  1  system clock; one clock domain, all state on rising edge.
- i_Rst  input  1  synchronous, active-high reset.
- i_Switch_1  input  1  raw, asynchronous mode-advance switch; 1 = pressed.
- i_Switch_2  input  1  raw, asynchronous pause switch; 1 = pressed.
- o_LED_1..o_LED_4  output  1 each  LED drives, registered.
- o_Mode  output  2  current mode, registered.
- o_Paused  output  1  pause flag, registered.

## Operation

- **Synchronizer.** Each raw switch passes through two flops, reset to 0.
- **Debounce.** One counter and one debounced level per switch; counters are sized for DEBOUNCE_LIMIT.
  - Counter clears whenever the synchronized value equals the debounced level.
  - Otherwise it increments.
  - After DEBOUNCE_LIMIT consecutive differing cycles, the debounced level takes the new value and the counter clears.
  - A glitch shorter than DEBOUNCE_LIMIT never changes the debounced level.
- **Events.** Each switch produces a one-cycle pulse when its debounced level goes 1→0. Press alone produces no event.
- **Mode FSM** (o_Mode encoding), advancing on switch 1 event: OFF(00) → ALL_ON(01) → BLINK(10) → CHASE(11) → OFF (wraps).
  - OFF: all LEDs 0.
  - ALL_ON: all LEDs 1.
  - BLINK: all four LEDs equal a phase bit. Phase = 1 on entry and toggles each tick.
  - CHASE: one-hot position. LED_1 on entry, then advances LED_1→LED_2→LED_3→LED_4→LED_1 each tick.
- **Tick timer.**
  - Counts 0..BLINK_HALF-1 and wraps.
  - A tick occurs on the cycle the count is BLINK_HALF-1.
  - Clears to 0 on every mode change, so the first tick after entry is exactly BLINK_HALF cycles later.
  - Runs in all modes; ticks only affect BLINK and CHASE.
- **Pause.**
  - A switch 2 event toggles o_Paused.
  - While paused: timer holds its value, no ticks occur, LED outputs are frozen.
  - Switch 1 events are still accepted while paused; a mode change clears o_Paused.
- **Simultaneous events** (switch 1 and switch 2 in the same cycle): mode advances and o_Paused ends 0. Switch 2 is ignored.

## Timing

- **Reset values:**
  - o_LED_1..4 = 0, o_Mode = 00, o_Paused = 0.
  - Timer, debounce counters, synchronizers and debounced levels = 0; blink phase = 1; chase position = LED_1.
- **Reset mid-operation:** any cycle with i_Rst = 1 forces the reset values on that edge, discarding in-flight debounce counts and pending events.
- **Event latency:** a raw switch release, held stable, updates o_Mode or o_Paused on rising edge DEBOUNCE_LIMIT+3. Edge 1 is the first edge sampling the new raw level.
- **Same-edge outputs:** o_Mode, o_LED_* and o_Paused update on the same edge; no output lags its state by a cycle.
- **Tick-driven updates:** LED changes occur on the edge where the tick cycle is registered.
- **Unpause resume:** timer resumes from its held value, so the first tick after unpause comes BLINK_HALF minus the elapsed count cycles later.
- **Held press:** a switch held pressed indefinitely generates no event until released.

## Test plan

All tests use DEBOUNCE_LIMIT = 4 and BLINK_HALF = 8.

1. **Reset:** assert i_Rst 3 cycles mid-CHASE → all LEDs 0, o_Mode = 00, o_Paused = 0 on the first edge with i_Rst = 1.
2. **Debounce:**
   - Press switch 1 for 20 cycles, then release → o_Mode 00→01 exactly on edge 7 after release; nothing changes at press.
   - Bounce 1/0 with 2-cycle periods for 20 cycles → no mode change.
3. **Full cycle:** four clean switch 1 releases → o_Mode goes 01, 10, 11, 00; LEDs 1111, 1111, 1000, 0000 (LED_1 first) on entry.
4. **BLINK:** enter BLINK → LEDs 1111 for 8 cycles, 0000 for 8, 1111 again.
5. **CHASE:** enter CHASE → lit LED sequence 1,2,3,4,1 with changes every 8 cycles.
6. **Pause:**
   - Pause in CHASE at timer count 3 → LEDs frozen for 50 cycles; unpause → next advance 5 cycles later.
   - Simultaneous switch 1 and switch 2 events → mode advances, o_Paused = 0.
